// File: rtl/result_seg_scan.sv
// Eight-digit hex scanner for the ALU result bus.
// New words are swapped in only at frame boundaries.
module result_seg_scan #(
    parameter int SCAN_DIV = 100000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [31:0] shown_value,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] presc;
    logic          pending;
    logic [31:0]   pend_word;
    logic          tick;
    logic          boundary;

    logic [4:0]    sh;
    logic [31:0]   upper;
    logic [3:0]    nib;
    logic          blank;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick     = (presc == LAST);
    assign boundary = tick && (digit_idx == 3'd7);
    assign dp       = 1'b1;

    // Prescaler, slot counter, and frame-aligned value swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            digit_idx   <= 3'd0;
            shown_value <= 32'h0;
            pending     <= 1'b0;
            pend_word   <= 32'h0;
            frame_done  <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + CW'(1);
            frame_done <= boundary;
            if (tick)
                digit_idx <= digit_idx + 3'd1;
            if (boundary) begin
                pending <= 1'b0;
                if (load)
                    shown_value <= value;
                else if (pending)
                    shown_value <= pend_word;
            end else if (load) begin
                pending   <= 1'b1;
                pend_word <= value;
            end
        end
    end

    // Select the nibble for this slot and decide blanking.
    always_comb begin
        sh       = {digit_idx, 2'b00};
        upper    = shown_value >> sh;
        nib      = upper[3:0];
        blank    = LZ_BLANK && (digit_idx != 3'd0)
                   && (upper == 32'h0);
        an_next  = ~(8'h01 << digit_idx);
        seg_next = hex7(nib);
        if (blank) begin
            an_next  = 8'hFF;
            seg_next = 7'h7F;
        end
    end

    // Registered pin drivers, one cycle behind the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
